// File: rtl/gcd_binary_unit.sv
// gcd_binary_unit: binary (Stein) GCD engine with valid/ready handshakes on
// both sides, zero-operand short-cut and a saturating per-operation cycle count.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   in_valid   operand pair a_i/b_i valid
//   in_ready   unit idle, accepts an operand pair (decoded from state)
//   a_i, b_i   unsigned operands
//   out_valid  result valid, held until out_ready (decoded from state)
//   out_ready  consumer accepts result
//   gcd_o      gcd(A,B); gcd(0,x)=x, gcd(0,0)=0
//   zero_o     1 when A==0 or B==0
//   cycles_o   clocks from acceptance to out_valid rise, saturating
//   busy_o     1 in any state other than IDLE (decoded from state)
module gcd_binary_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_o,
    output logic             zero_o,
    output logic [CNT_W-1:0] cycles_o,
    output logic             busy_o
);

    localparam int unsigned K_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STRIP,
        S_ODD,
        S_CMP,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a, a_nx;
    logic [WIDTH-1:0] b, b_nx;
    logic [K_W-1:0]   k, k_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic [WIDTH-1:0] gcd_nx;
    logic             zero_nx;
    logic [CNT_W-1:0] cycles_nx;

    // Handshake/status flags are pure decodes of the state register.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy_o    = (state != S_IDLE);

    // Saturating increment; the count stops at all-ones.
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            a        <= '0;
            b        <= '0;
            k        <= '0;
            cnt      <= '0;
            gcd_o    <= '0;
            zero_o   <= 1'b0;
            cycles_o <= '0;
        end else begin
            state    <= state_nx;
            a        <= a_nx;
            b        <= b_nx;
            k        <= k_nx;
            cnt      <= cnt_nx;
            gcd_o    <= gcd_nx;
            zero_o   <= zero_nx;
            cycles_o <= cycles_nx;
        end
    end

    // Next-state and datapath update: one action per cycle.
    always_comb begin
        state_nx  = state;
        a_nx      = a;
        b_nx      = b;
        k_nx      = k;
        cnt_nx    = cnt;
        gcd_nx    = gcd_o;
        zero_nx   = zero_o;
        cycles_nx = cycles_o;

        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
                    a_nx   = a_i;
                    b_nx   = b_i;
                    k_nx   = '0;
                    cnt_nx = CNT_W'(1);
                    if ((a_i == '0) || (b_i == '0)) begin
                        // gcd(0,x)=x; OR gives x (or 0 for both zero).
                        gcd_nx    = a_i | b_i;
                        zero_nx   = 1'b1;
                        cycles_nx = CNT_W'(1);
                        state_nx  = S_DONE;
                    end else begin
                        state_nx = S_STRIP;
                    end
                end
            end
            S_STRIP: begin
                cnt_nx = cnt_inc;
                // Pull out common factors of two; k remembers how many.
                if (!a[0] && !b[0]) begin
                    a_nx = a >> 1;
                    b_nx = b >> 1;
                    k_nx = k + K_W'(1);
                end else begin
                    state_nx = S_ODD;
                end
            end
            S_ODD: begin
                cnt_nx = cnt_inc;
                if (!a[0] || !b[0]) begin
                    if (!a[0]) a_nx = a >> 1;
                    if (!b[0]) b_nx = b >> 1;
                end else begin
                    state_nx = S_CMP;
                end
            end
            S_CMP: begin
                cnt_nx = cnt_inc;
                if (a == b) begin
                    state_nx = S_SHIFT;
                end else begin
                    if (a < b) b_nx = b - a;
                    else       a_nx = a - b;
                    state_nx = S_ODD;
                end
            end
            S_SHIFT: begin
                cnt_nx    = cnt_inc;
                gcd_nx    = a << k;
                zero_nx   = 1'b0;
                // Reported latency includes the entry clock into DONE.
                cycles_nx = cnt_inc;
                state_nx  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gcd_binary_unit.sv
// tb_gcd_binary_unit: directed and randomised checks of gcd_binary_unit at
// WIDTH=16 against hand-computed values and a Euclid reference function.
module tb_gcd_binary_unit;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned CNT_W   = 16;
    localparam int          LAT_MAX = 8 * WIDTH + 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gcd_o;
    logic             zero_o;
    logic [CNT_W-1:0] cycles_o;
    logic             busy_o;

    int n_checks = 0;
    int n_errors = 0;

    gcd_binary_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_in),
        .b_i       (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gcd_o     (gcd_o),
        .zero_o    (zero_o),
        .cycles_o  (cycles_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Euclid reference, deliberately a different algorithm from the DUT.
    function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] p, q, t;
        p = x;
        q = y;
        while (q != '0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // One full transaction: present, accept, wait for result, optional hold, retire.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit bp, input int hold,
                          output logic [WIDTH-1:0] g, output logic z,
                          output logic [CNT_W-1:0] c, output int lat,
                          output bit tmo, output bit stable, output logic ov_after);
        int  w;
        bit  r;
        tmo      = 1'b0;
        stable   = 1'b1;
        ov_after = 1'bx;
        g        = 'x;
        z        = 1'bx;
        c        = 'x;
        lat      = 0;
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < LAT_MAX) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            tmo      = 1'b1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat <= LAT_MAX);
        if (!out_valid) begin
            tmo = 1'b1;
            return;
        end
        g = gcd_o;
        z = zero_o;
        c = cycles_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!out_valid || gcd_o !== g || zero_o !== z || cycles_o !== c || in_ready !== 1'b0)
                stable = 1'b0;
        end
        for (int i = 0; i < 64; i++) begin
            r = (bp && i < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            @(posedge clk);
            #1 out_ready = 1'b0;
            if (r) break;
            @(negedge clk);
            if (!out_valid || gcd_o !== g || cycles_o !== c) stable = 1'b0;
        end
        @(negedge clk);
        ov_after = out_valid;
    endtask

    initial begin
        logic [WIDTH-1:0] g, ra, rb;
        logic             z, ov_after;
        logic [CNT_W-1:0] c;
        int               lat, w;
        bit               tmo, stable;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        #23;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_gcd", 32'(gcd_o), 32'd0);
        check("rst_zero", 32'(zero_o), 32'd0);
        check("rst_cycles", 32'(cycles_o), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);

        // 48,18 -> 6
        run_op(16'd48, 16'd18, 1'b0, 0, g, z, c, lat, tmo, stable, ov_after);
        check("g48_18_tmo", 32'(tmo), 32'd0);
        check("g48_18_gcd", 32'(g), 32'd6);
        check("g48_18_zero", 32'(z), 32'd0);
        check("g48_18_cycles", 32'(c), 32'(lat));
        check("g48_18_single", 32'(ov_after), 32'd0);

        // Zero operands
        run_op(16'd0, 16'd35, 1'b0, 0, g, z, c, lat, tmo, stable, ov_after);
        check("g0_35_gcd", 32'(g), 32'd35);
        check("g0_35_zero", 32'(z), 32'd1);
        check("g0_35_lat", 32'(lat), 32'd1);
        check("g0_35_cycles", 32'(c), 32'd1);
        run_op(16'd0, 16'd0, 1'b0, 0, g, z, c, lat, tmo, stable, ov_after);
        check("g0_0_gcd", 32'(g), 32'd0);
        check("g0_0_zero", 32'(z), 32'd1);
        run_op(16'd35, 16'd0, 1'b0, 0, g, z, c, lat, tmo, stable, ov_after);
        check("g35_0_gcd", 32'(g), 32'd35);
        check("g35_0_zero", 32'(z), 32'd1);

        // Full-width boundaries
        run_op(16'd32768, 16'd32768, 1'b0, 0, g, z, c, lat, tmo, stable, ov_after);
        check("g32768_gcd", 32'(g), 32'd32768);
        check("g32768_zero", 32'(z), 32'd0);
        check("g32768_lat", 32'(lat), 32'd20);
        run_op(16'd65535, 16'd65534, 1'b0, 0, g, z, c, lat, tmo, stable, ov_after);
        check("gmax_tmo", 32'(tmo), 32'd0);
        check("gmax_gcd", 32'(g), 32'd1);
        check("gmax_cycles", 32'(c), 32'(lat));
        run_op(16'd7, 16'd7, 1'b0, 0, g, z, c, lat, tmo, stable, ov_after);
        check("g7_7_gcd", 32'(g), 32'd7);
        check("g7_7_lat", 32'(lat), 32'd5);
        check("g7_7_cycles", 32'(c), 32'd5);

        // Backpressure: result held 20 cycles
        run_op(16'd100, 16'd75, 1'b0, 20, g, z, c, lat, tmo, stable, ov_after);
        check("bp_gcd", 32'(g), 32'd25);
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_retired", 32'(ov_after), 32'd0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        a_in     = 16'd65535;
        b_in     = 16'd65534;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_busy_before", 32'(busy_o), 32'd1);
        check("mid_ov_before", 32'(out_valid), 32'd0);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_ov", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("mid_after_ov", 32'(out_valid), 32'd0);
        check("mid_after_ready", 32'(in_ready), 32'd1);
        run_op(16'd12, 16'd8, 1'b0, 0, g, z, c, lat, tmo, stable, ov_after);
        check("post_rst_gcd", 32'(g), 32'd4);
        check("post_rst_zero", 32'(z), 32'd0);

        // out_ready and in_valid together in DONE: new operand waits for IDLE
        run_op(16'd9, 16'd6, 1'b0, 3, g, z, c, lat, tmo, stable, ov_after);
        check("pre_sim_gcd", 32'(g), 32'd3);
        @(negedge clk);
        a_in     = 16'd21;
        b_in     = 16'd14;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < LAT_MAX) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!out_valid && w <= LAT_MAX);
        check("sim_done_ov", 32'(out_valid), 32'd1);
        check("sim_done_gcd", 32'(gcd_o), 32'd7);
        a_in      = 16'd12;
        b_in      = 16'd8;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 check("sim_in_ready_done", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("sim_idle_ov", 32'(out_valid), 32'd0);
        check("sim_idle_ready", 32'(in_ready), 32'd1);
        check("sim_idle_gcd_held", 32'(gcd_o), 32'd7);
        @(posedge clk);
        #1 in_valid = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!out_valid && w <= LAT_MAX);
        check("sim_next_gcd", 32'(gcd_o), 32'd4);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Random pairs with random backpressure
        for (int n = 0; n < 400; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (n % 3 == 1) begin
                ra = ra & 16'h00FF;
                rb = (rb & 16'h003F) << 2;
            end
            if (n % 37 == 5) ra = '0;
            if (n % 41 == 7) rb = '0;
            run_op(ra, rb, 1'b1, 0, g, z, c, lat, tmo, stable, ov_after);
            check("rnd_tmo", 32'(tmo), 32'd0);
            check("rnd_gcd", 32'(g), 32'(ref_gcd(ra, rb)));
            check("rnd_zero", 32'(z), 32'((ra == '0) || (rb == '0)));
            check("rnd_stable", 32'(stable), 32'd1);
            check("rnd_no_dup", 32'(ov_after), 32'd0);
            if (tmo) break;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
